// File: rtl/vga_capture.sv
// vga_capture: measures VGA line/frame timing from hsync/vsync, declares lock
// once the timing is stable, and presents active-area pixels with coordinates.
//
// Parameters: H_ACTIVE/V_ACTIVE (active size), H_START/V_START (offset of the
// active area from the sync leading edges, in clocks/lines), SYNC_POL (sync
// active level, 0 = active-low).
// Ports:
//   clk, reset_n               pixel clock, asynchronous active-low reset
//   hsync, vsync, rrggbb       VGA source inputs
//   px_valid, px_x, px_y,      active pixel, its column/row and colour
//   px_data                    (2-clock latency from rrggbb)
//   h_total, v_total           measured clocks per line / lines per frame
//   locked                     timing stable
//   frame_start                one-cycle pulse per vsync leading edge
//   crc, crc_valid             per-frame CRC-16-CCITT of the pixels
// Optional feature: define VGA_CAPTURE_CRC_EN to build the frame CRC;
// otherwise crc and crc_valid are tied to 0.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_START  = 168,
  parameter int V_START  = 31,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rrggbb,
  output logic        px_valid,
  output logic [10:0] px_x,
  output logic [9:0]  px_y,
  output logic [5:0]  px_data,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic        locked,
  output logic        frame_start,
  output logic [15:0] crc,
  output logic        crc_valid
);

  localparam logic [11:0] H_LO = 12'(H_START);
  localparam logic [11:0] H_HI = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);
  localparam logic        ACT  = SYNC_POL;

  logic        hs_r, vs_r, hs_d_r, vs_d_r;
  logic [5:0]  rgb_r;
  logic [10:0] hcnt_r, hcnt_s;
  logic [9:0]  vcnt_r, vcnt_s;
  logic [10:0] h_prev_r, h_prev_s, h_total_s, meas_h_s;
  logic [9:0]  mv0_r, mv1_r, mv0_s, mv1_s, v_total_s;
  logic        hs_edge_s, vs_edge_s, hsat_s, vsat_s, disturb_s, lock_s, pix_s;

  // Input capture and edge history. Edge registers reset to the active level
  // so a sync already active at reset release is not seen as a leading edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_r   <= ACT;
      vs_r   <= ACT;
      hs_d_r <= ACT;
      vs_d_r <= ACT;
      rgb_r  <= 6'd0;
    end else begin
      hs_r   <= hsync;
      vs_r   <= vsync;
      hs_d_r <= hs_r;
      vs_d_r <= vs_r;
      rgb_r  <= rrggbb;
    end
  end

  assign hs_edge_s = (hs_r == ACT) && (hs_d_r != ACT);
  assign vs_edge_s = (vs_r == ACT) && (vs_d_r != ACT);
  assign hsat_s    = (hcnt_r == 11'h7FF);
  assign vsat_s    = (vcnt_r == 10'h3FF);
  assign meas_h_s  = hsat_s ? 11'h7FF : (hcnt_r + 11'd1);

  // Counter, measurement history and lock next-state.
  // mv0/mv1 are the lock history for meas_v; any line-length change or counter
  // saturation wipes it, so relock needs two fresh, equal frame measurements.
  always_comb begin
    hcnt_s    = hcnt_r;
    vcnt_s    = vcnt_r;
    h_total_s = h_total;
    h_prev_s  = h_prev_r;
    v_total_s = v_total;
    mv0_s     = mv0_r;
    mv1_s     = mv1_r;
    if (hs_edge_s) begin
      hcnt_s    = 11'd0;
      h_total_s = meas_h_s;
      h_prev_s  = h_total;
    end else if (!hsat_s) begin
      hcnt_s = hcnt_r + 11'd1;
    end else begin
      hcnt_s = hcnt_r;
    end
    // vsync wins over hsync for vcnt when both edges coincide.
    if (vs_edge_s) begin
      vcnt_s    = 10'd0;
      v_total_s = vcnt_r;
      mv1_s     = mv0_r;
      mv0_s     = vcnt_r;
    end else if (hs_edge_s && !vsat_s) begin
      vcnt_s = vcnt_r + 10'd1;
    end else begin
      vcnt_s = vcnt_r;
    end
    disturb_s = (hs_edge_s && (meas_h_s != h_total)) || hsat_s || vsat_s;
    if (disturb_s) begin
      mv0_s = 10'd0;
      mv1_s = 10'd0;
    end else begin
      mv0_s = mv0_s;
    end
    lock_s = (h_total_s == h_prev_s) && (mv0_s == mv1_s) && (mv0_s != 10'd0)
             && !hsat_s && !vsat_s;
    pix_s  = locked && ({1'b0, hcnt_r} >= H_LO) && ({1'b0, hcnt_r} < H_HI)
             && ({1'b0, vcnt_r} >= V_LO) && ({1'b0, vcnt_r} < V_HI);
  end

  // Timing state and measurement outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r      <= 11'd0;
      vcnt_r      <= 10'd0;
      h_total     <= 11'd0;
      h_prev_r    <= 11'd0;
      v_total     <= 10'd0;
      mv0_r       <= 10'd0;
      mv1_r       <= 10'd0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcnt_r      <= hcnt_s;
      vcnt_r      <= vcnt_s;
      h_total     <= h_total_s;
      h_prev_r    <= h_prev_s;
      v_total     <= v_total_s;
      mv0_r       <= mv0_s;
      mv1_r       <= mv1_s;
      locked      <= lock_s;
      frame_start <= vs_edge_s;
    end
  end

  // Pixel output stage; coordinates and data are forced to 0 outside the
  // active area.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_valid <= 1'b0;
      px_x     <= 11'd0;
      px_y     <= 10'd0;
      px_data  <= 6'd0;
    end else if (pix_s) begin
      px_valid <= 1'b1;
      px_x     <= hcnt_r - H_LO[10:0];
      px_y     <= vcnt_r - V_LO[9:0];
      px_data  <= rgb_r;
    end else begin
      px_valid <= 1'b0;
      px_x     <= 11'd0;
      px_y     <= 10'd0;
      px_data  <= 6'd0;
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  // CRC-16-CCITT (poly 0x1021), one byte MSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) begin
        r = {r[14:0], 1'b0} ^ 16'h1021;
      end else begin
        r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  logic [15:0] crc_run_r;

  // Running frame CRC; latched at the next vsync edge only if the frame was
  // captured while locked, then restarted for the new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_run_r <= 16'hFFFF;
      crc       <= 16'd0;
      crc_valid <= 1'b0;
    end else if (vs_edge_s) begin
      crc_run_r <= 16'hFFFF;
      if (locked) begin
        crc       <= crc_run_r;
        crc_valid <= 1'b1;
      end else begin
        crc_valid <= 1'b0;
      end
    end else begin
      crc_valid <= 1'b0;
      if (px_valid) begin
        crc_run_r <= crc16_byte(crc_run_r, {2'b00, px_data});
      end else begin
        crc_run_r <= crc_run_r;
      end
    end
  end
`else
  assign crc       = 16'd0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture using a reduced timing (32 clocks x 16 lines,
// 16x8 active area) so many frames fit in a short run. Expected pixels and
// frame CRCs go into queues as stimulus is driven; a monitor pops them.
module tb_vga_capture;

  localparam int LINE = 32;
  localparam int LINES = 16;

  logic        clk = 1'b0;
  logic        reset_n, hsync, vsync;
  logic [5:0]  rrggbb;
  logic        px_valid, locked, frame_start, crc_valid;
  logic [10:0] px_x, h_total;
  logic [9:0]  px_y, v_total;
  logic [5:0]  px_data;
  logic [15:0] crc;

  always #5 clk = ~clk;

  vga_capture #(.H_ACTIVE(16), .V_ACTIVE(8), .H_START(8), .V_START(4), .SYNC_POL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .rrggbb(rrggbb),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .h_total(h_total), .v_total(v_total), .locked(locked), .frame_start(frame_start),
    .crc(crc), .crc_valid(crc_valid)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [5:0]  d;
  } pix_t;

  pix_t        pix_q[$];
  logic [15:0] crc_q[$];
  pix_t        exp_pix;
  logic [15:0] exp_crc;
  logic [15:0] crc_model;
  int checks = 0, errors = 0;
  int fs_count = 0, fs_exp = 0, cv_count = 0, cv_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference CRC-16-CCITT, byte-at-a-time formulation.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic step(input logic hs_act, input logic vs_act, input logic [5:0] d);
    hsync  = ~hs_act;
    vsync  = ~vs_act;
    rrggbb = d;
    @(posedge clk);
    #2;
  endtask

  // One frame: hsync active cols 0..3, vsync leading edge at line 0 col 20.
  // Input column c of line L appears as pixel (c-9, L-4).
  task automatic run_frame(input bit pix_exp, input bit crc_latch, input bit zero_data,
                           input int long_line, input int rst_line);
    int len;
    logic vs;
    logic [5:0] dat;
    fs_exp++;
    if (crc_latch) begin
`ifdef VGA_CAPTURE_CRC_EN
      crc_q.push_back(crc_model);
      cv_exp++;
`endif
    end
    crc_model = 16'hFFFF;
    for (int line = 0; line < LINES; line++) begin
      len = (line == long_line) ? LINE + 1 : LINE;
      for (int col = 0; col < len; col++) begin
        dat = zero_data ? 6'd0 : 6'((line * 7 + col * 3) & 63);
        vs = (line == 0 && col >= 20) || (line == 1) || (line == 2 && col < 20);
        if (pix_exp && line >= 4 && line < 12 && col >= 9 && col < 25 &&
            (long_line < 0 || line <= long_line)) begin
          pix_q.push_back('{x: 11'(col - 9), y: 10'(line - 4), d: dat});
          crc_model = ref_crc(crc_model, {2'b00, dat});
        end
        step(col < 4, vs, dat);
        if (long_line >= 0 && line == long_line + 1 && col == 0) check("lock_before_drop", {31'd0, locked}, 32'd1);
        if (long_line >= 0 && line == long_line + 1 && col == 1) check("lock_drop", {31'd0, locked}, 32'd0);
        if (line == rst_line && col == 10) begin
          #1 reset_n = 1'b0;
          #1;
          check("rst_async_tot", {11'd0, h_total, v_total}, 32'd0);
          check("rst_async_misc", {12'd0, px_valid, locked, frame_start, crc_valid, crc}, 32'd0);
          check("rst_async_px", {5'd0, px_x, px_y, px_data}, 32'd0);
        end
        if (line == rst_line && col == 15) reset_n = 1'b1;
      end
    end
  endtask

  // Monitor: compares every presented pixel and CRC against the queues.
  always @(negedge clk) begin
    if (frame_start) fs_count++;
    if (px_valid) begin
      if (pix_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL px_unexpected actual=valid x=%0d y=%0d required=no_pixel", px_x, px_y);
      end else begin
        exp_pix = pix_q.pop_front();
        check("px", {5'd0, px_x, px_y, px_data}, {5'd0, exp_pix});
      end
    end else begin
      check("px_idle_zero", {5'd0, px_x, px_y, px_data}, 32'd0);
    end
    if (crc_valid) begin
      cv_count++;
      if (crc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL crc_unexpected actual=%0h required=no_crc", crc);
      end else begin
        exp_crc = crc_q.pop_front();
        check("crc", {16'd0, crc}, {16'd0, exp_crc});
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    rrggbb = 6'd0;
    crc_model = 16'hFFFF;
    repeat (3) @(posedge clk);
    #2;
    check("reset_tot", {11'd0, h_total, v_total}, 32'd0);
    check("reset_misc", {12'd0, px_valid, locked, frame_start, crc_valid, crc}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 6'd0);

    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    check("unlocked_before_f2", {31'd0, locked}, 32'd0);
    run_frame(1'b1, 1'b0, 1'b0, -1, -1);
    check("h_total", {21'd0, h_total}, 32'd32);
    check("v_total", {22'd0, v_total}, 32'd16);
    check("locked", {31'd0, locked}, 32'd1);
    run_frame(1'b1, 1'b1, 1'b1, -1, -1);
    run_frame(1'b1, 1'b1, 1'b0, 6, -1);
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    check("still_unlocked", {31'd0, locked}, 32'd0);
    run_frame(1'b1, 1'b0, 1'b0, -1, -1);
    check("relocked", {31'd0, locked}, 32'd1);
    run_frame(1'b1, 1'b1, 1'b0, -1, -1);

    for (int i = 0; i < 2200; i++) step(1'b0, 1'b0, 6'h15);
    check("nohsync_locked", {31'd0, locked}, 32'd0);
    check("nohsync_valid", {31'd0, px_valid}, 32'd0);

    run_frame(1'b0, 1'b0, 1'b0, -1, 5);
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);
    check("rst_not_yet_locked", {31'd0, locked}, 32'd0);
    run_frame(1'b1, 1'b0, 1'b0, -1, -1);
    check("rst_relocked", {31'd0, locked}, 32'd1);
    run_frame(1'b1, 1'b1, 1'b0, -1, -1);
    repeat (4) step(1'b0, 1'b0, 6'd0);

    check("pix_q_empty", pix_q.size(), 32'd0);
    check("crc_q_empty", crc_q.size(), 32'd0);
    check("frame_start_count", fs_count, fs_exp);
    check("crc_valid_count", cv_count, cv_exp);
`ifndef VGA_CAPTURE_CRC_EN
    check("crc_tied_zero", {16'd0, crc}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL provide parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL provide parameter H_START, default 168: clocks from the hsync leading edge to the first active pixel.
REQ-004 SHALL provide parameter V_START, default 31: lines from the vsync leading edge to the first active line.
REQ-005 SHALL provide parameter SYNC_POL, default 0: sync active level (0 = active-low).
REQ-006 SHALL have port clk, input, 1: pixel clock; single clock domain.
REQ-007 SHALL have port reset_n, input, 1: reset; asynchronous, active-low.
REQ-008 SHALL have port hsync, input, 1: horizontal sync from the VGA source.
REQ-009 SHALL have port vsync, input, 1: vertical sync from the VGA source.
REQ-010 SHALL have port rrggbb, input, 6: pixel colour.
REQ-011 SHALL have port px_valid, output, 1: an active pixel is presented this cycle.
REQ-012 SHALL have port px_x, output, 11: active column, 0..H_ACTIVE-1.
REQ-013 SHALL have port px_y, output, 10: active row, 0..V_ACTIVE-1.
REQ-014 SHALL have port px_data, output, 6: captured colour.
REQ-015 SHALL have port h_total, output, 11: measured clocks per line.
REQ-016 SHALL have port v_total, output, 10: measured lines per frame.
REQ-017 SHALL have port locked, output, 1: timing is stable.
REQ-018 SHALL have port frame_start, output, 1: one-cycle pulse at each vsync leading edge.
REQ-019 SHALL have port crc, output, 16: checksum of the last complete frame.
REQ-020 SHALL have port crc_valid, output, 1: one-cycle pulse when crc updates.

Function
REQ-021 SHALL register hsync, vsync and rrggbb once, and detect leading edges (inactive->active per SYNC_POL) on the registered copies.
REQ-022 SHALL clear hcnt (11 bit) on an hsync edge, otherwise increment it, saturating at 2047.
REQ-023 SHALL, on each hsync edge, compute meas_h = hcnt+1, load it into h_total, and increment vcnt (10 bit, saturating at 1023).
REQ-024 SHALL, on a vsync edge, compute meas_v = vcnt, load it into v_total, clear vcnt and pulse frame_start.
REQ-025 SHALL, when vsync and hsync edges coincide, apply the vsync rule to vcnt and the hsync rule to hcnt/h_total.
REQ-026 SHALL set locked when the two most recent meas_h are equal, the two most recent meas_v are equal, and meas_v is nonzero.
REQ-027 SHALL clear locked the cycle after any meas_h or meas_v differs from its predecessor, and on hcnt or vcnt saturation.
REQ-028 SHALL assert px_valid only when locked, H_START<=hcnt<H_START+H_ACTIVE, and V_START<=vcnt<V_START+V_ACTIVE.
REQ-029 SHALL drive px_x = hcnt-H_START, px_y = vcnt-V_START and px_data = registered rrggbb, all registered.
REQ-030 SHALL give total latency of 2 clocks from rrggbb input to px_data output, with px_x/px_y aligned to px_data.
REQ-031 SHALL drive px_x, px_y and px_data to 0 when px_valid is low.

Reset
REQ-032 SHALL, while reset_n is low, clear all counters, measurement history, locked, px_valid, px_x, px_y, px_data, h_total, v_total, frame_start, crc and crc_valid to 0.
REQ-033 SHALL, on reset deassertion mid-frame, keep locked low until two full frames have been measured.
REQ-034 SHALL clear edge-detect registers so that a sync that is active when reset releases is not counted as an edge.

Configuration
REQ-035 SHALL use macro VGA_CAPTURE_CRC_EN; when it is defined, compute CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over {2'b00,px_data} for every px_valid cycle.
REQ-036 SHALL, with VGA_CAPTURE_CRC_EN defined, latch the running CRC into crc on a vsync edge when locked, pulse crc_valid, and then reinit the running CRC to 0xFFFF.
REQ-037 SHALL, without VGA_CAPTURE_CRC_EN, tie crc to 0 and crc_valid to 0 and synthesize no CRC logic.

Verification
REQ-038 SHALL cover: drive 832x520 timing (hsync 40 clocks active-low, vsync 3 lines) for 3 frames -> h_total=832, v_total=520, locked high by the end of frame 2.
REQ-039 SHALL cover: constant rrggbb=6'h2A while locked -> exactly 640x480 px_valid cycles per frame, first with px_x=0/px_y=0, last with px_x=639/px_y=479, px_data=6'h2A.
REQ-040 SHALL cover: lengthen one line to 833 clocks -> locked drops the next cycle after that hsync edge and recovers after two consistent frames.
REQ-041 SHALL cover: remove hsync entirely -> hcnt saturates at 2047, locked=0, px_valid=0.
REQ-042 SHALL cover: assert reset_n low mid-line for 5 clocks -> all outputs 0 immediately (asynchronously); no px_valid until relock.
REQ-043 SHALL cover: with VGA_CAPTURE_CRC_EN defined and all pixels 0 -> crc equals the reference-model CRC of 307200 zero bytes on each frame_start, crc_valid 1 cycle.
